// File: rtl/rle1_dec_if.sv
// Token-in / beat-out handshake bundle for the single-bit run-length decoder.
// master drives tokens and beat acceptance; slave is the decoder side.
interface rle1_dec_if #(
   parameter int CNT_W = 4
);
   logic [CNT_W+1:0] input_r;
   logic             input_r_vld;
   logic             input_r_rdy;
   logic [1:0]       output_s;
   logic             output_s_vld;
   logic             output_s_rdy;

   modport master (
      output input_r, input_r_vld, output_s_rdy,
      input  input_r_rdy, output_s, output_s_vld
   );

   modport slave (
      input  input_r, input_r_vld, output_s_rdy,
      output input_r_rdy, output_s, output_s_vld
   );
endinterface

// File: rtl/rle1_dec.sv
// Expands {last, count, symbol} tokens into count symbol beats; first beat one cycle after accept.
// Stalls hold the beat stable; a new token is taken only when idle or as the final beat leaves.
module rle1_dec #(
   parameter int CNT_W = 4
) (
   input  logic     clk,
   input  logic     reset,
   rle1_dec_if.slave bus
);
   typedef enum logic {EMPTY = 1'b0, EXPAND = 1'b1} state_t;

   logic [CNT_W-1:0] rem;
   logic [CNT_W-1:0] rem_nxt;
   logic             sym_q;
   logic             sym_nxt;
   logic             last_q;
   logic             last_nxt;
   state_t           state;
   logic             final_beat;
   logic             beat_take;
   logic             tok_take;

   assign state      = (rem != '0) ? EXPAND : EMPTY;
   assign final_beat = (rem == CNT_W'(1));
   assign beat_take  = bus.output_s_vld & bus.output_s_rdy;
   assign tok_take   = bus.input_r_vld & bus.input_r_rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rem    <= '0;
         sym_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         rem    <= rem_nxt;
         sym_q  <= sym_nxt;
         last_q <= last_nxt;
      end
   end

   // A token load overrides the decrement; a count-0 token loads 0 and emits nothing.
   always_comb begin
      rem_nxt  = rem;
      sym_nxt  = sym_q;
      last_nxt = last_q;
      if (tok_take) begin
         rem_nxt  = bus.input_r[CNT_W:1];
         sym_nxt  = bus.input_r[0];
         last_nxt = bus.input_r[CNT_W+1];
      end else if (beat_take) begin
         rem_nxt  = rem - CNT_W'(1);
      end
   end

   always_comb begin
      bus.output_s_vld = 1'b0;
      bus.output_s     = 2'b00;
      bus.input_r_rdy  = 1'b1;
      if (state == EXPAND) begin
         bus.output_s_vld = 1'b1;
         bus.output_s     = {last_q & final_beat, sym_q};
         // Combinational path from output_s_rdy lets back-to-back runs flow without a bubble.
         bus.input_r_rdy  = final_beat & bus.output_s_rdy;
      end
   end
endmodule

// File: tb/tb_rle1_dec.sv
// Directed bench for rle1_dec: stimulus pushes expected beats, a negedge monitor pops and compares.
module tb_rle1_dec;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   n_chk = 0;
   int   n_fail = 0;
   int   n_beats = 0;
   logic [1:0] exp_q[$];

   rle1_dec_if #(.CNT_W(4)) bus ();

   rle1_dec #(.CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
      end
   endtask

   // Inputs change 1 time unit after posedge, so at negedge they reflect the upcoming edge.
   always @(negedge clk) begin
      if (reset && bus.output_s_vld && bus.output_s_rdy) begin
         n_beats++;
         if (exp_q.size() == 0) begin
            chk("unexpected_beat", {30'd0, bus.output_s}, 32'hFFFF_FFFF);
         end else begin
            chk("beat_data", {30'd0, bus.output_s}, {30'd0, exp_q.pop_front()});
         end
      end
   end

   task automatic push_exp(input logic [5:0] tok);
      int cnt;
      cnt = int'(tok[4:1]);
      for (int i = 0; i < cnt; i++)
         exp_q.push_back({tok[5] && (i == cnt - 1), tok[0]});
   endtask

   // Presents tok until it transfers; returns 1 unit after the accepting edge.
   task automatic send(input logic [5:0] tok, input logic push);
      bit done;
      done = 1'b0;
      if (push) push_exp(tok);
      bus.input_r     = tok;
      bus.input_r_vld = 1'b1;
      for (int c = 0; c < 200 && !done; c++) begin
         @(negedge clk);
         if (bus.input_r_rdy) done = 1'b1;
         @(posedge clk);
         #1;
      end
      bus.input_r_vld = 1'b0;
      if (!done) chk("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      bit idle;
      idle = 1'b0;
      for (int c = 0; c < 100 && !idle; c++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !bus.output_s_vld) idle = 1'b1;
      end
      chk("drain_queue_empty", exp_q.size(), 32'd0);
   endtask

   initial begin
      int b0;
      logic pat[7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      bus.input_r      = '0;
      bus.input_r_vld  = 1'b0;
      bus.output_s_rdy = 1'b1;

      // Reset values while reset is held.
      repeat (2) @(negedge clk);
      chk("rst_vld", bus.output_s_vld, 0);
      chk("rst_out", bus.output_s, 0);
      chk("rst_rdy", bus.input_r_rdy, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("post_rst_rdy", bus.input_r_rdy, 1);

      // Basic run: three contiguous beats 01,01,11 then idle.
      @(posedge clk); #1;
      send(6'b100111, 1'b1);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("basic_vld", bus.output_s_vld, 1);
      end
      @(negedge clk);
      chk("basic_idle_vld", bus.output_s_vld, 0);
      chk("basic_idle_rdy", bus.input_r_rdy, 1);

      // Back-to-back: 00,00,11 with no bubble; rdy rises when rem==1.
      @(posedge clk); #1;
      send(6'b000100, 1'b1);
      fork
         send(6'b100011, 1'b1);
         begin
            @(negedge clk);
            chk("b2b_vld0", bus.output_s_vld, 1);
            chk("b2b_rdy_rem2", bus.input_r_rdy, 0);
            @(negedge clk);
            chk("b2b_vld1", bus.output_s_vld, 1);
            chk("b2b_rdy_rem1", bus.input_r_rdy, 1);
            @(negedge clk);
            chk("b2b_vld2", bus.output_s_vld, 1);
            chk("b2b_out2", bus.output_s, 2'b11);
            @(negedge clk);
            chk("b2b_idle", bus.output_s_vld, 0);
         end
      join
      drain();

      // Backpressure: cnt=4 sym=1 with ready pattern 1,0,0,1,1,0,1.
      @(posedge clk); #1;
      send(6'b001001, 1'b1);
      for (int c = 0; c < 7; c++) begin
         bus.output_s_rdy = pat[c];
         @(negedge clk);
         chk("bp_vld", bus.output_s_vld, 1);
         chk("bp_out_stable", bus.output_s, 2'b01);
         chk("bp_in_rdy", bus.input_r_rdy, (c == 6) ? 1 : 0);
         @(posedge clk); #1;
      end
      bus.output_s_rdy = 1'b1;
      @(negedge clk);
      chk("bp_done_vld", bus.output_s_vld, 0);

      // Zero count token is swallowed; only beat is 00.
      @(posedge clk); #1;
      b0 = n_beats;
      send(6'b100001, 1'b1);
      @(negedge clk);
      chk("zero_no_beat", bus.output_s_vld, 0);
      @(posedge clk); #1;
      send(6'b000010, 1'b1);
      drain();
      chk("zero_beat_count", n_beats - b0, 1);

      // Max run: 14 x 00 then 10.
      @(posedge clk); #1;
      b0 = n_beats;
      send(6'b111110, 1'b1);
      drain();
      chk("max_beat_count", n_beats - b0, 15);

      // Reset after 2 of 7 beats: remaining beats lost.
      @(posedge clk); #1;
      exp_q.push_back(2'b01);
      exp_q.push_back(2'b01);
      send(6'b001111, 1'b0);
      repeat (2) @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      chk("midrst_vld", bus.output_s_vld, 0);
      chk("midrst_out", bus.output_s, 0);
      chk("midrst_rdy", bus.input_r_rdy, 1);
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      chk("after_rst_vld", bus.output_s_vld, 0);
      chk("after_rst_rdy", bus.input_r_rdy, 1);
      chk("midrst_queue", exp_q.size(), 0);
      @(posedge clk); #1;
      b0 = n_beats;
      send(6'b100101, 1'b1);
      drain();
      chk("after_rst_count", n_beats - b0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/rle1_dec.md
# rle1_dec

Single-bit run-length decoder, downstream consumer of the rle1 encoder's token stream. Each accepted 6-bit token (symbol, run length, last flag) is expanded into `count` consecutive 2-bit symbol beats in the encoder's own input format. An encode→decode loop therefore returns the original stream. The block occupies the `bus_rle1_dec_in` / `bus_rle1_dec_out` slot of the top-level pin demux/mux.

## Interface
Parameters:
- `CNT_W`, default 4: run-length field width; max run length 2^CNT_W−1 = 15.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low (0 = reset); release is synchronous to `clk`.
- `rle1__input_r`  in  6  token: [0] symbol, [4:1] run length, [5] last.
- `rle1__input_r_vld`  in  1  token valid.
- `rle1__input_r_rdy`  out  1  token accept; transfer occurs when `vld & rdy` at a rising edge.
- `rle1__output_s`  out  2  beat: [0] symbol, [1] last.
- `rle1__output_s_vld`  out  1  beat valid.
- `rle1__output_s_rdy`  in  1  downstream accept; transfer occurs when `vld & rdy`.

Pin mapping in the wrapper:
- `bus_rle1_dec_in`: [0] clk, [1] reset, [7:2] input_r, [8] input_r_vld, [9] output_s_rdy; [18:10] unused.
- `bus_rle1_dec_out`: [1:0] output_s, [2] output_s_vld, [3] input_r_rdy; [7:4] driven 0.

## Operation
State registers:
- `rem` (CNT_W bits): beats left in the current run.
- `sym_q`, `last_q`: symbol and last flag of the current token.

States:
- EMPTY (`rem == 0`).
- EXPAND (`rem != 0`).

Outputs:
- `output_s_vld = (rem != 0)`.
- `output_s = {last_q & (rem == 1), sym_q}`. Last is flagged only on the final beat of a last-token run.
- `input_r_rdy = (rem == 0) | (rem == 1 & output_s_rdy)`. This is a combinational path from `output_s_rdy`, allowed so that back-to-back runs have no bubble.

Per-edge update:
- Beat taken (`vld & output_s_rdy`) and no token accepted: `rem <= rem − 1`.
- Token accepted (`input_r_vld & input_r_rdy`): `rem <= input_r[4:1]`, `sym_q <= input_r[0]`, `last_q <= input_r[5]`. This overrides the decrement; it is legal only when the current run is finishing or when EMPTY.
- Neither: hold.

Boundary cases:
- Count-0 token: accepted and consumed; `rem` loads 0; no beat is emitted. Its last flag is discarded.
- Count 15: exactly 15 beats are emitted; no wrap-around.
- Stall (`output_s_rdy = 0`): the output holds stable with vld high; `input_r_rdy` is 0 while EXPAND.
- Reset asserted mid-run: immediately `rem = 0`, `sym_q = 0`, `last_q = 0`. The remaining beats are lost; no partial output appears after release.

## Timing
- Reset values: `output_s = 2'b00`, `output_s_vld = 0`. `input_r_rdy = 1` during and after reset.
- Latency: token accepted at edge N; its first beat is valid in the cycle after edge N.
- Throughput: 1 beat/cycle sustained across tokens when `output_s_rdy = 1` and the next token is presented while `rem == 1`.
- A run of length k occupies exactly k unstalled cycles.
- Upstream must hold the token stable until `rdy`; the decoder samples only on transfer.
- All state is registered. `input_r_rdy` is the only output with a combinational input dependency (on `output_s_rdy`).

## Test plan
- Reset, then token {last=1, cnt=3, sym=1} (6'b100111) with `output_s_rdy = 1` → beats 2'b01, 2'b01, 2'b11 on three consecutive cycles; then vld = 0 and rdy = 1.
- Back-to-back: tokens {0, cnt=2, sym=0} and {1, cnt=1, sym=1} presented continuously → beats 00, 00, 11 with no idle cycle; `input_r_rdy` is high in the cycle `rem == 1`.
- Backpressure: cnt=4 sym=1 with `output_s_rdy` toggling 1,0,0,1,1,0,1 → exactly 4 beats of 2'b01; the output is stable during stalls; `input_r_rdy` stays 0 until the last beat transfers.
- Zero count: {last=1, cnt=0, sym=1}, then {last=0, cnt=1, sym=0} → the first token is consumed with no beat; the only beat is 2'b00.
- Max run: cnt=15 sym=0 last=1 → 14 beats of 00 followed by one 10; total 15.
- Reset mid-run: assert reset after 2 of 7 beats → vld drops asynchronously. After release, vld = 0, rdy = 1, and the next token decodes normally.
- Loopback: random 200-bit stream through `rle1_enc_wrap` → `rle1_dec` → output symbols and last flag match the input exactly.
